// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver.
// rxd is synchronised and then sampled at the centre of each bit. The timing
// comes from an OVERSAMPLE x baud tick divider, and that divider restarts on
// every start edge. A good frame loads rx_data and raises rx_valid for one
// clock. A stop bit sampled low raises frame_err for one clock, and the
// receiver then waits for the line to go high again before it looks for a
// new start edge.
module uart_rx_byte #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,      // synchronous, active-high: 1 = reset
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV  = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int S_W   = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic               r_sync1;
    logic               r_rxs;
    logic               r_rxs_d;
    logic [DIV_W-1:0]   r_div;
    logic [S_W-1:0]     r_s;
    logic [2:0]         r_bit;
    logic [7:0]         r_shreg;

    logic               w_fall;
    logic               w_tick;
    logic               w_mid_start;
    logic               w_mid_bit;
    logic               w_start_go;
    logic               w_shift;
    logic               w_load;
    logic               w_ferr;

    // A falling edge on the synchronised line marks a possible start bit.
    assign w_fall = r_rxs_d & ~r_rxs;

    // The divider runs only while a frame is in progress.
    assign w_tick = (r_state != S_IDLE) && (r_div == DIV_W'(DIV - 1));

    // The start bit is checked at its centre, OVERSAMPLE/2 ticks after the edge.
    assign w_mid_start = w_tick && (r_s == S_W'(OVERSAMPLE / 2 - 1));

    // The sample counter is cleared at the start-bit centre, so every later bit
    // centre falls a full OVERSAMPLE ticks after the one before it.
    assign w_mid_bit = w_tick && (r_s == S_W'(OVERSAMPLE - 1));

    // Two-flop synchroniser plus a delayed copy used for edge detection.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rxs   <= r_sync1;
            r_rxs_d <= r_rxs;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_next = S_START;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_START: begin
                if (w_mid_start) begin
                    w_next = r_rxs ? S_IDLE : S_DATA;
                end else begin
                    w_next = S_START;
                end
            end
            S_DATA: begin
                if (w_mid_bit && (r_bit == 3'd7)) begin
                    w_next = S_STOP;
                end else begin
                    w_next = S_DATA;
                end
            end
            S_STOP: begin
                if (w_mid_bit) begin
                    w_next = r_rxs ? S_IDLE : S_BREAK;
                end else begin
                    w_next = S_STOP;
                end
            end
            S_BREAK: begin
                if (r_rxs) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_BREAK;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Per-state action strobes that drive the datapath and the output registers.
    always_comb begin
        w_start_go = 1'b0;
        w_shift    = 1'b0;
        w_load     = 1'b0;
        w_ferr     = 1'b0;
        case (r_state)
            S_START: begin
                w_start_go = w_mid_start & ~r_rxs;
            end
            S_DATA: begin
                w_shift = w_mid_bit;
            end
            S_STOP: begin
                w_load = w_mid_bit & r_rxs;
                w_ferr = w_mid_bit & ~r_rxs;
            end
            default: begin
                w_start_go = 1'b0;
            end
        endcase
    end

    // Tick divider: held at zero while idle, so the bit phase locks to the start edge.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_div <= '0;
        end else if ((r_state == S_IDLE) || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Sample counter: counts ticks within a bit and is cleared at the start-bit centre.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_s <= '0;
        end else if ((r_state == S_IDLE) || w_start_go) begin
            r_s <= '0;
        end else if (w_tick) begin
            if (r_s == S_W'(OVERSAMPLE - 1)) begin
                r_s <= '0;
            end else begin
                r_s <= r_s + S_W'(1);
            end
        end else begin
            r_s <= r_s;
        end
    end

    // Bit index and shift register; the data arrives LSB first.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_bit   <= 3'd0;
            r_shreg <= 8'h00;
        end else begin
            if (r_state != S_DATA) begin
                r_bit <= 3'd0;
            end else if (w_shift) begin
                r_bit <= r_bit + 3'd1;
            end else begin
                r_bit <= r_bit;
            end
            if (w_shift) begin
                r_shreg[r_bit] <= r_rxs;
            end else begin
                r_shreg <= r_shreg;
            end
        end
    end

    // Registered outputs. busy follows the next state, so it falls in the same
    // cycle the FSM enters IDLE.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= w_load;
            frame_err <= w_ferr;
            busy      <= (w_next != S_IDLE);
            if (w_load) begin
                rx_data <= r_shreg;
            end else begin
                rx_data <= rx_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte. The design runs at CLK_FREQ=1.6 MHz,
// BAUD=10k and OVERSAMPLE=16, so DIV=10 and one bit lasts 160 clocks.
module tb_uart_rx_byte;

    localparam int BIT_CLKS = 160;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int         checks;
    int         errors;
    int         valid_cnt;
    int         ferr_cnt;
    int         overlap_cnt;
    logic [7:0] vlog [0:15];
    int         v0;
    int         f0;

    uart_rx_byte #(
        .CLK_FREQ  (1_600_000),
        .BAUD      (10_000),
        .OVERSAMPLE(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts valid/error cycles and logs the delivered bytes.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (valid_cnt < 16) vlog[valid_cnt] = rx_data;
            valid_cnt = valid_cnt + 1;
        end
        if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
        if ((rx_valid === 1'b1) && (frame_err === 1'b1)) overlap_cnt = overlap_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rxd = 1'b0;
        hold(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            hold(BIT_CLKS);
        end
        rxd = stop_bit;
        hold(BIT_CLKS);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        valid_cnt   = 0;
        ferr_cnt    = 0;
        overlap_cnt = 0;
        rst_n       = 1'b1;
        rxd         = 1'b1;

        // 1: reset state
        hold(3);
        chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b0;
        hold(20);

        // 2: good frame 0xA5
        v0 = valid_cnt;
        send_frame(8'hA5, 1'b1);
        hold(10);
        chk("a5_valid_cnt", valid_cnt - v0, 32'd1);
        chk("a5_data", {24'd0, rx_data}, 32'hA5);
        chk("a5_log", {24'd0, vlog[0]}, 32'hA5);
        chk("a5_ferr_cnt", ferr_cnt, 32'd0);
        chk("a5_busy_low", {31'd0, busy}, 32'd0);

        // 3: false start, low for 40 clocks only
        v0 = valid_cnt;
        rxd = 1'b0;
        hold(20);
        chk("fs_busy_high", {31'd0, busy}, 32'd1);
        hold(20);
        rxd = 1'b1;
        hold(200);
        chk("fs_busy_low", {31'd0, busy}, 32'd0);
        chk("fs_no_valid", valid_cnt - v0, 32'd0);
        chk("fs_no_ferr", ferr_cnt, 32'd0);
        chk("fs_data_kept", {24'd0, rx_data}, 32'hA5);

        // 4: 0x3C with a low stop bit, line held low for 500 clocks in total
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        hold(500 - BIT_CLKS);
        chk("brk_busy_high", {31'd0, busy}, 32'd1);
        chk("brk_ferr_cnt", ferr_cnt - f0, 32'd1);
        rxd = 1'b1;
        hold(20);
        chk("brk_busy_low", {31'd0, busy}, 32'd0);
        hold(2000);
        chk("brk_no_valid", valid_cnt - v0, 32'd0);
        chk("brk_ferr_once", ferr_cnt - f0, 32'd1);
        chk("brk_data_kept", {24'd0, rx_data}, 32'hA5);

        // 5: back-to-back 0x00 then 0xFF
        v0 = valid_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        hold(10);
        chk("b2b_valid_cnt", valid_cnt - v0, 32'd2);
        chk("b2b_first", {24'd0, vlog[v0[3:0]]}, 32'h00);
        chk("b2b_second", {24'd0, vlog[(v0 + 1) & 15]}, 32'hFF);
        chk("b2b_data", {24'd0, rx_data}, 32'hFF);

        // 6: reset during bit 4 of 0x5A, then receive 0x81
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rxd = 1'b0;
        hold(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rxd = (i == 1 || i == 3) ? 1'b1 : 1'b0;
            hold(BIT_CLKS);
        end
        rxd = 1'b1;
        hold(BIT_CLKS / 2);
        rst_n = 1'b1;
        hold(3);
        rst_n = 1'b0;
        hold(1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_data_reset", {24'd0, rx_data}, 32'h00);
        hold(1000);
        chk("abort_no_valid", valid_cnt - v0, 32'd0);
        send_frame(8'h81, 1'b1);
        hold(10);
        chk("r81_valid_cnt", valid_cnt - v0, 32'd1);
        chk("r81_data", {24'd0, rx_data}, 32'h81);
        chk("r81_no_ferr", ferr_cnt - f0, 32'd0);
        chk("never_overlap", overlap_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
